ptr_serial_arbiter: RTL

PTR_SERIAL_ARBITER -- requirements
Module: ptr_serial_arbiter

---
 rtl/cdi_pkg.sv | 19 +
 rtl/bytestream.sv | 8 +
 rtl/byte_fifo.sv | 49 ++++
 rtl/ptr_serial_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cdi_pkg.sv
// Shared constants and types for the CDI serial host link (arbiter and pointing device).
package cdi_pkg;

    localparam int               CDI_CNT_W        = 19;
    localparam logic [18:0]      CDI_TICKS_NORMAL = 19'd250000;
    localparam logic [18:0]      CDI_TICKS_FAST   = 19'd200000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_FLUSH = 2'd2
    } cdi_state_e;

    // Bytes 10xxxxxx continue a frame; everything else opens one.
    function automatic logic is_continuation(input logic [7:0] b);
        return b[7:6] == 2'b10;
    endfunction

endpackage

// File: rtl/bytestream.sv
// Single-cycle write strobe with an 8-bit payload.
interface bytestream;
    logic       write;
    logic [7:0] data;

    modport sink   (input  write, input  data);
    modport source (output write, output data);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with first-word-fall-through head; full push is ignored unless a pop frees a slot.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ptr_serial_arbiter.sv
// Merges two framed byte streams onto one paced serial link; a granted frame is never interleaved.
module ptr_serial_arbiter
    import cdi_pkg::*;
#(
    parameter int                   FIFO_DEPTH   = 8,
    parameter int                   LOCK_TIMEOUT = 2,
    parameter logic [CDI_CNT_W-1:0] NORMAL_TICKS = CDI_TICKS_NORMAL,
    parameter logic [CDI_CNT_W-1:0] FAST_TICKS   = CDI_TICKS_FAST
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       overclock,
    input  logic       rts,
    bytestream.sink    in0,
    bytestream.sink    in1,
    bytestream.source  serial_out,
    output logic [1:0] overflow,
    output logic [1:0] grant
);

    localparam int TO_W = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);

    cdi_state_e           state, state_nxt;
    logic                 owner, owner_nxt;
    logic                 rr_ptr, rr_ptr_nxt;
    logic [TO_W-1:0]      to_cnt, to_nxt, to_inc;
    logic [CDI_CNT_W-1:0] pace_cnt, reload_val;
    logic                 opp;
    logic [1:0]           push, pop, full, empty, cont, elig;
    logic [7:0]           din  [2];
    logic [7:0]           head [2];
    logic                 pick;
    logic                 vld_p0, vld_p1;
    logic [7:0]           data_p0, data_p1;

    assign push    = {in1.write, in0.write} & {2{~rts}};
    assign din[0]  = in0.data;
    assign din[1]  = in1.data;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (rts),
        .push   (push[0]),
        .pop    (pop[0]),
        .din    (din[0]),
        .head   (head[0]),
        .full   (full[0]),
        .empty  (empty[0])
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (rts),
        .push   (push[1]),
        .pop    (pop[1]),
        .din    (din[1]),
        .head   (head[1]),
        .full   (full[1]),
        .empty  (empty[1])
    );

    assign cont[0] = ~empty[0] & is_continuation(head[0]);
    assign cont[1] = ~empty[1] & is_continuation(head[1]);
    assign elig    = ~empty & ~cont;
    assign pick    = (&elig) ? rr_ptr : elig[1];
    assign to_inc  = to_cnt + 1'b1;

    // Period is exactly the tick count: reload happens on the cycle the count would hit zero.
    assign reload_val = overclock ? FAST_TICKS : NORMAL_TICKS;
    assign opp        = (pace_cnt == CDI_CNT_W'(1)) && !rts && (state != ST_FLUSH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pace_cnt <= NORMAL_TICKS;
        end else if (rts || pace_cnt <= CDI_CNT_W'(1)) begin
            pace_cnt <= reload_val;
        end else begin
            pace_cnt <= pace_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            owner  <= 1'b0;
            rr_ptr <= 1'b0;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            to_cnt <= to_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        to_nxt     = to_cnt;
        pop        = 2'b00;
        vld_p0     = 1'b0;
        data_p0    = 8'h00;
        if (rts) begin
            state_nxt = ST_FLUSH;
            to_nxt    = '0;
        end else begin
            case (state)
                ST_FLUSH: state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (opp) begin
                        // Orphans are dropped in the same opportunity a frame start may be granted.
                        pop = cont;
                        if (elig != 2'b00) begin
                            pop[pick]  = 1'b1;
                            vld_p0     = 1'b1;
                            data_p0    = head[pick];
                            owner_nxt  = pick;
                            rr_ptr_nxt = ~pick;
                            to_nxt     = '0;
                            state_nxt  = ST_OWNED;
                        end
                    end
                end
                ST_OWNED: begin
                    if (opp) begin
                        if (cont[owner]) begin
                            pop[owner] = 1'b1;
                            vld_p0     = 1'b1;
                            data_p0    = head[owner];
                            to_nxt     = '0;
                        end else if (!empty[owner]) begin
                            state_nxt = ST_IDLE;
                            to_nxt    = '0;
                        end else if (push[owner]) begin
                            to_nxt = '0;
                        end else if (to_inc >= TO_W'(LOCK_TIMEOUT)) begin
                            state_nxt = ST_IDLE;
                            to_nxt    = '0;
                        end else begin
                            to_nxt = to_inc;
                        end
                    end else if (push[owner]) begin
                        to_nxt = '0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow <= 2'b00;
        end else begin
            overflow <= overflow | (push & full & ~pop);
        end
    end

    // p0 -> p1: registered output strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= 8'h00;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) data_p1 <= data_p0;
        end
    end

    assign serial_out.write = vld_p1;
    assign serial_out.data  = data_p1;
    assign grant = (state == ST_OWNED) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
